// File: rtl/phase_a_sequencer_if.sv
// Bundle between the phase_a sequencer, the exponentiation control FSM and the phase_a datapath.
// The master view is the sequencer. The slave view is its environment.
interface phase_a_sequencer_if #(
  parameter int Size  = 3072,
  parameter int CNT_W = 8
);
  logic             start;
  logic [Size-1:0]  a_in;
  logic [CNT_W-1:0] iter_num;
  logic             busy;
  logic             done;
  logic             err;
  logic [Size-1:0]  result;
  logic             pa_en;
  logic [Size-1:0]  pa_a;
  logic             pa_done;
  logic [Size-1:0]  pa_new_a;

  modport master (
    input  start, a_in, iter_num, pa_done, pa_new_a,
    output busy, done, err, result, pa_en, pa_a
  );

  modport slave (
    output start, a_in, iter_num, pa_done, pa_new_a,
    input  busy, done, err, result, pa_en, pa_a
  );
endinterface

// File: rtl/phase_a_sequencer.sv
// Drives phase_a for a programmed number of passes, feeding each new_a back as the next operand.
// Includes a watchdog that ends the run with err set if phase_a never answers.
module phase_a_sequencer #(
  parameter int Size    = 3072,
  parameter int CNT_W   = 8,
  parameter int GAP_CYC = 2,
  parameter int TIMEOUT = 63
) (
  input  logic                 clk,
  input  logic                 rst_n,
  phase_a_sequencer_if.master  bus
);

  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_GAP    = 3'd3,
    S_FINISH = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [Size-1:0]  pa_a_q, pa_a_d;
  logic [Size-1:0]  result_q, result_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             pa_en_q, pa_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  assign cnt_inc_s = cnt_q + 1'b1;

  // State and output registers; every output leaves the block straight from a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pa_a_q   <= '0;
      result_q <= '0;
      iter_q   <= '0;
      cnt_q    <= '0;
      wd_q     <= '0;
      gap_q    <= '0;
      pa_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pa_a_q   <= pa_a_d;
      result_q <= result_d;
      iter_q   <= iter_d;
      cnt_q    <= cnt_d;
      wd_q     <= wd_d;
      gap_q    <= gap_d;
      pa_en_q  <= pa_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic; pa_en and done are one-cycle strobes, everything else holds by default.
  always_comb begin
    state_d  = state_q;
    pa_a_d   = pa_a_q;
    result_d = result_q;
    iter_d   = iter_q;
    cnt_d    = cnt_q;
    wd_d     = wd_q;
    gap_d    = gap_q;
    pa_en_d  = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          pa_a_d = bus.a_in;
          iter_d = bus.iter_num;
          cnt_d  = '0;
          err_d  = 1'b0;
          busy_d = 1'b1;
          if (bus.iter_num == '0) begin
            result_d = bus.a_in;
            state_d  = S_FINISH;
          end else begin
            state_d  = S_ISSUE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ISSUE: begin
        pa_en_d = 1'b1;
        wd_d    = '0;
        state_d = S_WAIT;
      end

      // A response in the expiry cycle still counts as success.
      S_WAIT: begin
        wd_d = wd_q + 1'b1;
        if (bus.pa_done) begin
          pa_a_d = bus.pa_new_a;
          cnt_d  = cnt_inc_s;
          if (cnt_inc_s == iter_q) begin
            result_d = bus.pa_new_a;
            state_d  = S_FINISH;
          end else begin
            gap_d   = '0;
            state_d = S_GAP;
          end
        end else if (wd_q == WD_LAST) begin
          err_d    = 1'b1;
          result_d = pa_a_q;
          state_d  = S_FINISH;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_ISSUE;
        end else begin
          gap_d   = gap_q + 1'b1;
          state_d = S_GAP;
        end
      end

      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.pa_en  = pa_en_q;
  assign bus.pa_a   = pa_a_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_phase_a_sequencer.sv
// Bench for phase_a_sequencer: a fixed-latency phase_a model that returns a+1.
// Expected results come from plain arithmetic (a_in + passes), and a monitor watches the pa_en/pa_a protocol.
module tb_phase_a_sequencer;

  localparam int SIZE    = 3072;
  localparam int CNT_W   = 8;
  localparam int GAP_CYC = 2;
  localparam int TIMEOUT = 63;
  localparam int LAT     = 20;
  localparam int BUDGET  = 8000;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  phase_a_sequencer_if #(.Size(SIZE), .CNT_W(CNT_W)) bus ();

  phase_a_sequencer #(
    .Size(SIZE), .CNT_W(CNT_W), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // phase_a model: pa_done comes LAT cycles after the en rising edge and returns the captured a plus one.
  int              timer       = 0;
  logic            en_prev_mod = 1'b0;
  logic [SIZE-1:0] a_cap       = '0;
  bit              respond     = 1'b1;

  always begin
    @(posedge clk);
    #1;
    bus.pa_done  = 1'b0;
    bus.pa_new_a = ~a_cap;
    if (timer > 0) begin
      timer--;
      if (timer == 0 && respond) begin
        bus.pa_done  = 1'b1;
        bus.pa_new_a = a_cap + 1'b1;
      end
    end
    if (bus.pa_en === 1'b1 && en_prev_mod !== 1'b1) begin
      timer = LAT;
      a_cap = bus.pa_a;
    end
    en_prev_mod = bus.pa_en;
  end

  // Protocol monitor: pulse count, pulse width, low gap, and operand stability while a pass is outstanding.
  int              pulse_total   = 0;
  int              pa_done_total = 0;
  int              viol_width    = 0;
  int              viol_gap      = 0;
  int              viol_stable   = 0;
  time             last_pulse_t  = 0;
  logic            en_prev_m     = 1'b0;
  int              low_run       = 0;
  bit              seen_pulse    = 1'b0;
  bit              outstanding   = 1'b0;
  logic [SIZE-1:0] held_a        = '0;

  always @(negedge clk) begin
    if (bus.pa_done === 1'b1) pa_done_total++;
    if (bus.pa_en === 1'b1) begin
      if (en_prev_m === 1'b1) begin
        viol_width++;
      end else begin
        pulse_total++;
        last_pulse_t = $time;
        if (seen_pulse && low_run < GAP_CYC) viol_gap++;
        seen_pulse  = 1'b1;
        outstanding = 1'b1;
        held_a      = bus.pa_a;
      end
      low_run = 0;
    end else begin
      low_run++;
    end
    if (outstanding) begin
      if (bus.pa_a !== held_a) viol_stable++;
      if (bus.pa_done === 1'b1 || bus.busy !== 1'b1) outstanding = 1'b0;
    end
    if (bus.busy !== 1'b1) seen_pulse = 1'b0;
    en_prev_m = bus.pa_en;
  end

  task automatic chk(input string tag, input logic [SIZE-1:0] obs, input logic [SIZE-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed(low64)=%0h expected(low64)=%0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  function automatic logic [SIZE-1:0] rand_wide();
    logic [SIZE-1:0] v;
    v = '0;
    for (int i = 0; i < SIZE / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // One start-to-done transaction; optionally re-asserts start (with a2) from cycle restart_at until done appears.
  task automatic run_op(input string tag, input logic [SIZE-1:0] a, input int n, input bit resp,
                        input int restart_at, input logic [SIZE-1:0] a2,
                        input logic [SIZE-1:0] exp_res, input bit exp_err, input int exp_pulses,
                        output int lat, output time done_t);
    int p0, v0, k;
    bit got, busy_ok;
    respond = resp;
    p0 = pulse_total;
    v0 = viol_width + viol_gap + viol_stable;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.a_in     = a;
    bus.iter_num = CNT_W'(n);
    k = 0; got = 1'b0; busy_ok = 1'b1; done_t = 0;
    while (!got && k < BUDGET) begin
      @(negedge clk);
      k++;
      if (bus.done === 1'b1) begin
        got    = 1'b1;
        done_t = $time;
      end else if (bus.busy !== 1'b1) begin
        busy_ok = 1'b0;
      end
      if (!got && restart_at != 0 && k >= restart_at) begin
        bus.start = 1'b1;
        bus.a_in  = a2;
      end else begin
        bus.start = 1'b0;
      end
    end
    lat = k;
    chk({tag, "_done_seen"}, SIZE'(got), SIZE'(1));
    chk({tag, "_busy_hold"}, SIZE'(busy_ok), SIZE'(1));
    chk({tag, "_busy_low_at_done"}, SIZE'(bus.busy), SIZE'(0));
    chk({tag, "_err"}, SIZE'(bus.err), SIZE'(exp_err));
    chk({tag, "_result"}, bus.result, exp_res);
    chk({tag, "_pulses"}, SIZE'(pulse_total - p0), SIZE'(exp_pulses));
    chk({tag, "_protocol"}, SIZE'(viol_width + viol_gap + viol_stable - v0), SIZE'(0));
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, SIZE'(bus.done), SIZE'(0));
    chk({tag, "_idle_after"}, SIZE'(bus.busy), SIZE'(0));
  endtask

  initial begin
    logic [SIZE-1:0] a, ones;
    int   lat, n, p0, d0;
    time  dt;
    bit   done_any, seen;

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.a_in     = '0;
    bus.iter_num = '0;
    repeat (2) @(negedge clk);
    chk("rst_pa_en", SIZE'(bus.pa_en), SIZE'(0));
    chk("rst_pa_a", bus.pa_a, SIZE'(0));
    chk("rst_busy", SIZE'(bus.busy), SIZE'(0));
    chk("rst_done", SIZE'(bus.done), SIZE'(0));
    chk("rst_err", SIZE'(bus.err), SIZE'(0));
    chk("rst_result", bus.result, SIZE'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op("basic", SIZE'(5), 3, 1'b1, 0, '0, SIZE'(8), 1'b0, 3, lat, dt);

    run_op("zero_iter", SIZE'(16'h1234), 0, 1'b1, 0, '0, SIZE'(16'h1234), 1'b0, 0, lat, dt);
    chk("zero_iter_latency", SIZE'(lat), SIZE'(2));

    a = rand_wide();
    run_op("timeout", a, 2, 1'b0, 0, '0, a, 1'b1, 1, lat, dt);
    chk("timeout_latency", SIZE'(dt - last_pulse_t), SIZE'((TIMEOUT + 1) * 10));

    // Second start held high while busy and through FINISH must be ignored.
    run_op("restart_busy", SIZE'(7), 1, 1'b1, 3, SIZE'(99), SIZE'(8), 1'b0, 1, lat, dt);
    repeat (2) @(negedge clk);
    chk("restart_result_hold", bus.result, SIZE'(8));
    chk("restart_still_idle", SIZE'(bus.busy), SIZE'(0));
    run_op("restart_idle", SIZE'(99), 1, 1'b1, 0, '0, SIZE'(100), 1'b0, 1, lat, dt);

    // Reset mid-WAIT; phase_a's late answer must be ignored.
    respond = 1'b1;
    p0 = pulse_total;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.a_in     = rand_wide();
    bus.iter_num = CNT_W'(1);
    @(negedge clk);
    bus.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (pulse_total != p0) seen = 1'b1;
    end
    chk("mid_rst_pulse_seen", SIZE'(seen), SIZE'(1));
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_pa_en", SIZE'(bus.pa_en), SIZE'(0));
    chk("mid_rst_pa_a", bus.pa_a, SIZE'(0));
    chk("mid_rst_busy", SIZE'(bus.busy), SIZE'(0));
    chk("mid_rst_done", SIZE'(bus.done), SIZE'(0));
    chk("mid_rst_err", SIZE'(bus.err), SIZE'(0));
    chk("mid_rst_result", bus.result, SIZE'(0));
    d0 = pa_done_total;
    done_any = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_any = 1'b1;
    end
    chk("late_pa_done_fired", SIZE'(pa_done_total - d0), SIZE'(1));
    chk("late_pa_a", bus.pa_a, SIZE'(0));
    chk("late_result", bus.result, SIZE'(0));
    chk("late_no_activity", SIZE'(done_any), SIZE'(0));
    run_op("post_rst", SIZE'(3), 1, 1'b1, 0, '0, SIZE'(4), 1'b0, 1, lat, dt);

    for (int r = 0; r < 6; r++) begin
      a = rand_wide();
      n = $urandom_range(0, 5);
      run_op($sformatf("rand%0d", r), a, n, 1'b1, 0, '0, a + SIZE'(n), 1'b0, n, lat, dt);
    end

    ones = '1;
    run_op("carry", ones, 2, 1'b1, 0, '0, SIZE'(1), 1'b0, 2, lat, dt);

    a = rand_wide();
    run_op("max_iter", a, 255, 1'b1, 0, '0, a + SIZE'(255), 1'b0, 255, lat, dt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
